// File: rtl/uart_core.sv
// uart_core: parametrised full-duplex UART with valid/ready handshakes and RX error reporting.
// TX and RX are independent FSMs sharing the clock; RX input is double-flop synchronised.
module uart_core #(
   parameter int DATA_BITS    = 8,
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
)(
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_tx_valid,
   output logic                 o_tx_ready,
   input  logic [DATA_BITS-1:0] i_tx_data,
   output logic                 o_tx,
   input  logic                 i_rx,
   output logic                 o_rx_valid,
   input  logic                 i_rx_ready,
   output logic [DATA_BITS-1:0] o_rx_data,
   output logic                 o_rx_parity_err,
   output logic                 o_rx_frame_err,
   output logic                 o_rx_overrun
);
   if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY_MODE > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_chk
      $error("uart_core: illegal parameter value");
   end

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2);
   localparam logic [3:0]    D_LAST  = 4'(DATA_BITS - 1);
   localparam logic [3:0]    S_LAST  = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t r_tx_state, w_tx_state_nxt;
   logic [CW-1:0] r_tx_cnt;
   logic [3:0] r_tx_idx;
   logic [DATA_BITS-1:0] r_tx_shift;
   logic r_tx_par;
   logic w_tx_bit_end, w_tx_accept;

   assign w_tx_bit_end = r_tx_cnt == BIT_END;
   assign w_tx_accept  = i_tx_valid && o_tx_ready;
   // Ready in the final stop-bit cycle lets the next start bit follow with no idle gap
   assign o_tx_ready = r_tx_state == IDLE || (r_tx_state == STOP && w_tx_bit_end && r_tx_idx == S_LAST);
   assign o_tx = (r_tx_state == START) ? 1'b0 : (r_tx_state == DATA) ? r_tx_shift[0] :
                 (r_tx_state == PARITY) ? r_tx_par : 1'b1;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_tx_state <= IDLE;
      else          r_tx_state <= w_tx_state_nxt;

   always_comb begin
      w_tx_state_nxt = r_tx_state;
      case (r_tx_state)
         IDLE:    if (w_tx_accept) w_tx_state_nxt = START;
         START:   if (w_tx_bit_end) w_tx_state_nxt = DATA;
         DATA:    if (w_tx_bit_end && r_tx_idx == D_LAST) w_tx_state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:  if (w_tx_bit_end) w_tx_state_nxt = STOP;
         default: if (o_tx_ready) w_tx_state_nxt = i_tx_valid ? START : IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_tx_cnt   <= '0;
         r_tx_idx   <= '0;
         r_tx_shift <= '0;
         r_tx_par   <= 1'b0;
      end else begin
         r_tx_cnt <= (r_tx_state == IDLE || w_tx_bit_end) ? '0 : r_tx_cnt + 1'b1;
         if (w_tx_accept) begin
            r_tx_shift <= i_tx_data;
            r_tx_par   <= ^i_tx_data ^ (PARITY_MODE == 2);
         end else if (r_tx_state == DATA && w_tx_bit_end)
            r_tx_shift <= r_tx_shift >> 1;
         if (w_tx_bit_end) r_tx_idx <= (w_tx_state_nxt != r_tx_state) ? '0 : r_tx_idx + 1'b1;
      end

   state_t r_rx_state, w_rx_state_nxt;
   logic r_rx_s1, r_rx_s2, r_rx_prev;
   logic [CW-1:0] r_rx_cnt;
   logic [3:0] r_rx_idx;
   logic [DATA_BITS-1:0] r_rx_shift;
   logic r_rx_perr;
   logic w_rx, w_rx_sample, w_rx_done, w_rx_hs;

   assign w_rx        = r_rx_s2;
   assign w_rx_sample = (r_rx_state == START) ? r_rx_cnt == HALF : r_rx_cnt == BIT_END;
   assign w_rx_done   = r_rx_state == STOP && w_rx_sample;
   assign w_rx_hs     = o_rx_valid && i_rx_ready;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_rx_state <= IDLE;
      else          r_rx_state <= w_rx_state_nxt;

   // Edge detect needs a high-then-low pair, so a held-low break line cannot re-trigger
   always_comb begin
      w_rx_state_nxt = r_rx_state;
      case (r_rx_state)
         IDLE:    if (r_rx_prev && !w_rx) w_rx_state_nxt = START;
         START:   if (w_rx_sample) w_rx_state_nxt = w_rx ? IDLE : DATA;
         DATA:    if (w_rx_sample && r_rx_idx == D_LAST) w_rx_state_nxt = (PARITY_MODE != 0) ? PARITY : STOP;
         PARITY:  if (w_rx_sample) w_rx_state_nxt = STOP;
         default: if (w_rx_sample) w_rx_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_rx_s1         <= 1'b1;
         r_rx_s2         <= 1'b1;
         r_rx_prev       <= 1'b1;
         r_rx_cnt        <= '0;
         r_rx_idx        <= '0;
         r_rx_shift      <= '0;
         r_rx_perr       <= 1'b0;
         o_rx_valid      <= 1'b0;
         o_rx_data       <= '0;
         o_rx_parity_err <= 1'b0;
         o_rx_frame_err  <= 1'b0;
         o_rx_overrun    <= 1'b0;
      end else begin
         r_rx_s1   <= i_rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         r_rx_cnt  <= (r_rx_state == IDLE || w_rx_sample) ? '0 : r_rx_cnt + 1'b1;
         if (w_rx_sample) r_rx_idx <= (w_rx_state_nxt != r_rx_state) ? '0 : r_rx_idx + 1'b1;
         if (r_rx_state == DATA && w_rx_sample) r_rx_shift <= {w_rx, r_rx_shift[DATA_BITS-1:1]};
         if (r_rx_state == PARITY && w_rx_sample) r_rx_perr <= ^r_rx_shift ^ w_rx ^ (PARITY_MODE == 2);
         if (w_rx_done && (!o_rx_valid || w_rx_hs)) begin
            o_rx_valid      <= 1'b1;
            o_rx_data       <= r_rx_shift;
            o_rx_parity_err <= (PARITY_MODE != 0) && r_rx_perr;
            o_rx_frame_err  <= !w_rx;
         end else if (w_rx_hs)
            o_rx_valid <= 1'b0;
         o_rx_overrun <= !w_rx_hs && (o_rx_overrun || (w_rx_done && o_rx_valid));
      end
endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: randomized self-checking bench for uart_core against a frame-level reference model.
// Three instances: no parity (TX timing, break), even parity loopback, odd parity with two stop bits.
module tb_uart_core;
   localparam int CPB = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic tx_valid0 = 0, tx_ready0, tx0, rx0 = 1, rx_valid0, rx_ready0 = 0, perr0, ferr0, ovr0;
   logic tx_valid1 = 0, tx_ready1, tx1, rx_valid1, rx_ready1 = 0, perr1, ferr1, ovr1;
   logic tx_valid2 = 0, tx_ready2, tx2, rx2 = 1, rx_valid2, rx_ready2 = 0, perr2, ferr2, ovr2;
   logic [7:0] tx_data0 = 0, tx_data1 = 0, tx_data2 = 0, rx_data0, rx_data1, rx_data2;

   uart_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(0), .STOP_BITS(1)) u_dut0 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid0), .o_tx_ready(tx_ready0), .i_tx_data(tx_data0),
      .o_tx(tx0), .i_rx(rx0), .o_rx_valid(rx_valid0), .i_rx_ready(rx_ready0), .o_rx_data(rx_data0),
      .o_rx_parity_err(perr0), .o_rx_frame_err(ferr0), .o_rx_overrun(ovr0));

   uart_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(1), .STOP_BITS(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid1), .o_tx_ready(tx_ready1), .i_tx_data(tx_data1),
      .o_tx(tx1), .i_rx(tx1), .o_rx_valid(rx_valid1), .i_rx_ready(rx_ready1), .o_rx_data(rx_data1),
      .o_rx_parity_err(perr1), .o_rx_frame_err(ferr1), .o_rx_overrun(ovr1));

   uart_core #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_MODE(2), .STOP_BITS(2)) u_dut2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_tx_valid(tx_valid2), .o_tx_ready(tx_ready2), .i_tx_data(tx_data2),
      .o_tx(tx2), .i_rx(rx2), .o_rx_valid(rx_valid2), .i_rx_ready(rx_ready2), .o_rx_data(rx_data2),
      .o_rx_parity_err(perr2), .o_rx_frame_err(ferr2), .o_rx_overrun(ovr2));

   int n_total = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Serial level of bit slot idx of a frame: start, LSB-first data, optional parity, then stop/idle high
   function automatic logic frame_bit(input logic [7:0] w, input int idx, input int pm);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return w[idx-1];
      if (pm != 0 && idx == 9) return ($countones(w) % 2 == 1) != (pm == 2);
      return 1'b1;
   endfunction

   task automatic drive(input int which, input logic [7:0] w, input logic pb, input logic sb);
      logic [12:0] fr;
      fr = (which == 0) ? {3'b111, sb, w, 1'b0} : {2'b11, sb, pb, w, 1'b0};
      for (int b = 0; b < 13; b++) begin
         if (which == 0) rx0 = fr[b];
         else rx2 = fr[b];
         repeat (CPB) tick;
      end
   endtask

   int n_w0 = 0;
   logic [7:0] last_d0 = 0;
   logic last_f0 = 0;
   always @(negedge clk)
      if (rst_n && rx_valid0 && rx_ready0) begin
         n_w0 <= n_w0 + 1;
         last_d0 <= rx_data0;
         last_f0 <= ferr0;
      end

   initial begin
      #2000000;
      $display("FAIL watchdog total=%0d", n_total);
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] words [5];
      logic [7:0] w;
      logic pb, sb, ptx;
      int n, base;
      repeat (3) tick;
      check("rst_tx", tx0, 1);
      check("rst_tx_ready", tx_ready0, 1);
      check("rst_rx_valid", rx_valid0, 0);
      check("rst_rx_data", rx_data0, 0);
      check("rst_flags", {perr0, ferr0, ovr0}, 0);
      rst_n = 1'b1;
      tick;

      tx_valid1 = 1; tx_data1 = 8'($urandom);
      tick;
      tx_valid1 = 0;
      repeat (50) tick;
      check("mid_tx_busy", tx_ready1, 0);
      #3 rst_n = 1'b0;
      #1;
      check("async_tx", tx1, 1);
      check("async_tx_ready", tx_ready1, 1);
      repeat (3) tick;
      rst_n = 1'b1;
      n = 0;
      for (int i = 0; i < 400; i++) begin
         if (rx_valid1) n++;
         tick;
      end
      check("rst_no_word", n, 0);

      words[0] = 8'h55; words[1] = 8'h37; words[2] = 8'h13;
      words[3] = 8'($urandom); words[4] = 8'($urandom);
      check("tx0_idle_ready", tx_ready0, 1);
      tx_valid0 = 1; tx_data0 = words[0];
      tick;
      for (int k = 0; k < 5; k++)
         for (int c = 0; c < 160; c++) begin
            check("tx0_bit", tx0, frame_bit(words[k], c / CPB, 0));
            check("tx0_ready", tx_ready0, c == 159);
            if (c == 5) tx_data0 = 8'($urandom);
            if (c == 159) begin
               if (k < 4) tx_data0 = words[k+1];
               else tx_valid0 = 0;
            end
            tick;
         end
      check("tx0_end_line", tx0, 1);
      check("tx0_end_ready", tx_ready0, 1);

      w = 8'($urandom);
      tx_valid2 = 1; tx_data2 = w;
      tick;
      tx_valid2 = 0;
      for (int c = 0; c < 192; c++) begin
         if (c % CPB == CPB / 2) check("tx2_bit", tx2, frame_bit(w, c / CPB, 2));
         if (c == 190) check("tx2_busy", tx_ready2, 0);
         if (c == 191) check("tx2_ready", tx_ready2, 1);
         tick;
      end

      for (int k = 0; k < 7; k++) begin
         w = (k == 0) ? 8'h37 : 8'($urandom);
         n = 0;
         while (!tx_ready1 && n < 400) begin tick; n++; end
         tx_valid1 = 1; tx_data1 = w;
         tick;
         tx_valid1 = 0;
         n = 0; ptx = 1'bx;
         while (!rx_valid1 && n < 400) begin
            if (n == 9 * CPB + CPB / 2) ptx = tx1;
            tick;
            n++;
         end
         check("lb_valid", rx_valid1, 1);
         check("lb_parity_bit", ptx, frame_bit(w, 9, 1));
         check("lb_data", rx_data1, w);
         check("lb_errs", {perr1, ferr1}, 0);
         rx_ready1 = 1;
         tick;
         rx_ready1 = 0;
         check("lb_clear", rx_valid1, 0);
      end

      drive(2, 8'h13, 1'b1, 1'b1);
      repeat (20) tick;
      check("p2_hold", rx_valid2, 1);
      check("p2_data", rx_data2, 8'h13);
      check("p2_perr", perr2, 1);
      check("p2_ferr", ferr2, 0);
      rx_ready2 = 1;
      tick;
      rx_ready2 = 0;
      check("p2_clear", rx_valid2, 0);
      for (int k = 0; k < 8; k++) begin
         w = 8'($urandom); pb = 1'($urandom); sb = ($urandom % 4) != 0;
         drive(2, w, pb, sb);
         check("p2r_valid", rx_valid2, 1);
         check("p2r_data", rx_data2, w);
         check("p2r_perr", perr2, ($countones(w) + pb) % 2 == 0);
         check("p2r_ferr", ferr2, !sb);
         rx_ready2 = 1;
         tick;
         rx_ready2 = 0;
      end

      rx_ready0 = 1;
      base = n_w0;
      rx0 = 0;
      repeat (20 * CPB) tick;
      rx0 = 1;
      repeat (100) tick;
      check("brk_count", n_w0 - base, 1);
      check("brk_data", last_d0, 0);
      check("brk_ferr", last_f0, 1);
      drive(0, 8'hC3, 1'b0, 1'b1);
      check("brk_rearm_count", n_w0 - base, 2);
      check("brk_rearm_data", last_d0, 8'hC3);
      check("brk_rearm_ferr", last_f0, 0);
      rx_ready0 = 0;

      drive(2, 8'hA5, 1'b1, 1'b1);
      check("ovr_first", ovr2, 0);
      drive(2, 8'h5A, 1'b1, 1'b1);
      check("ovr_valid", rx_valid2, 1);
      check("ovr_data", rx_data2, 8'hA5);
      check("ovr_perr", perr2, 0);
      check("ovr_flag", ovr2, 1);
      rx_ready2 = 1;
      tick;
      rx_ready2 = 0;
      check("ovr_clr_valid", rx_valid2, 0);
      check("ovr_clr_flag", ovr2, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule
